// File: rtl/ahb_led_sequencer_if.sv
// ahb_led_sequencer_if: groups the sequencer's control, config, status and AHB-Lite master signals.
// Ports: start/stop/one_shot and cfg_* in; HREADY in; HADDR/HTRANS/HWRITE/HSIZE/HWDATA, busy/step/wrap out.
interface ahb_led_sequencer_if #(parameter int DIV_WIDTH = 24);
    logic                 start;
    logic                 stop;
    logic                 one_shot;
    logic                 cfg_we;
    logic [2:0]           cfg_addr;
    logic [7:0]           cfg_wdata;
    logic [2:0]           cfg_len;
    logic [DIV_WIDTH-1:0] cfg_period;
    logic [7:0]           cfg_mask;
    logic                 HREADY;
    logic [31:0]          HADDR;
    logic [1:0]           HTRANS;
    logic                 HWRITE;
    logic [2:0]           HSIZE;
    logic [31:0]          HWDATA;
    logic                 busy;
    logic [2:0]           step;
    logic                 wrap;
    modport master (
        input  start, stop, one_shot, cfg_we, cfg_addr, cfg_wdata, cfg_len, cfg_period, cfg_mask, HREADY,
        output HADDR, HTRANS, HWRITE, HSIZE, HWDATA, busy, step, wrap
    );
    modport slave (
        output start, stop, one_shot, cfg_we, cfg_addr, cfg_wdata, cfg_len, cfg_period, cfg_mask, HREADY,
        input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA, busy, step, wrap
    );
endinterface

// File: rtl/ahb_led_sequencer.sv
// ahb_led_sequencer: AHB-Lite master that writes the LED mask once, then plays an 8-entry pattern table.
// Ports: HCLK clock, HRESET sync active-high reset, bus (master modport) carrying control, config and AHB signals.
module ahb_led_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'h5000_0000,
    parameter int          DIV_WIDTH = 24
) (
    input logic                 HCLK,
    input logic                 HRESET,
    ahb_led_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, MASK_A, MASK_D, DATA_A, DATA_D, WAIT} state_t;
    localparam logic [1:0] NONSEQ = 2'b10;

    state_t               state_q, state_d;
    logic [7:0]           tbl_q [8];
    logic [2:0]           idx_q, len_q, step_q;
    logic                 one_shot_q, stop_q, wrap_q, hwrite_q;
    logic [7:0]           mask_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [31:0]          haddr_q, hwdata_q;
    logic [1:0]           htrans_q;
    logic                 stop_any, last, addr_d;

    // A stop arriving this cycle acts immediately, same as one already pending.
    always_comb begin
        stop_any = bus.stop | stop_q;
        last     = idx_q == len_q;
        state_d  = state_q;
        case (state_q)
            IDLE:    state_d = (bus.start && !bus.stop) ? MASK_A : IDLE;
            MASK_A:  state_d = bus.HREADY ? MASK_D : MASK_A;
            MASK_D:  state_d = !bus.HREADY ? MASK_D : stop_any ? IDLE : DATA_A;
            DATA_A:  state_d = bus.HREADY ? DATA_D : DATA_A;
            DATA_D:  state_d = !bus.HREADY ? DATA_D :
                               (stop_any || (last && one_shot_q)) ? IDLE :
                               (bus.cfg_period == '0) ? DATA_A : WAIT;
            WAIT:    state_d = stop_any ? IDLE : (cnt_q <= DIV_WIDTH'(1)) ? DATA_A : WAIT;
            default: state_d = IDLE;
        endcase
        addr_d = state_d == MASK_A || state_d == DATA_A;
    end

    // Bus outputs are registered from the next state so each address phase starts cleanly on a clock edge.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= IDLE;
            for (int i = 0; i < 8; i++) tbl_q[i] <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            step_q     <= '0;
            one_shot_q <= 1'b0;
            stop_q     <= 1'b0;
            wrap_q     <= 1'b0;
            hwrite_q   <= 1'b0;
            mask_q     <= '0;
            cnt_q      <= '0;
            haddr_q    <= '0;
            hwdata_q   <= '0;
            htrans_q   <= '0;
        end else begin
            state_q  <= state_d;
            htrans_q <= addr_d ? NONSEQ : 2'b00;
            hwrite_q <= addr_d;
            stop_q   <= state_d != IDLE && stop_any;
            wrap_q   <= 1'b0;
            if (bus.cfg_we) tbl_q[bus.cfg_addr] <= bus.cfg_wdata;
            if (state_d == MASK_A) haddr_q <= BASE_ADDR + 32'd1;
            if (state_d == DATA_A) haddr_q <= BASE_ADDR;
            if (state_q == IDLE && state_d == MASK_A) begin
                len_q      <= bus.cfg_len;
                one_shot_q <= bus.one_shot;
                mask_q     <= bus.cfg_mask;
                idx_q      <= '0;
            end
            if (state_q == MASK_A && bus.HREADY) hwdata_q <= {24'h0, mask_q};
            // The entry is read as its address phase is accepted, so live table writes are picked up.
            if (state_q == DATA_A && bus.HREADY) hwdata_q <= {24'h0, tbl_q[idx_q]};
            if (state_q == DATA_D && bus.HREADY) begin
                step_q <= idx_q;
                cnt_q  <= bus.cfg_period;
                wrap_q <= last;
                idx_q  <= last ? 3'd0 : idx_q + 3'd1;
            end
            if (state_q == WAIT) cnt_q <= cnt_q - DIV_WIDTH'(1);
        end
    end

    assign bus.HADDR  = haddr_q;
    assign bus.HTRANS = htrans_q;
    assign bus.HWRITE = hwrite_q;
    assign bus.HSIZE  = 3'b000;
    assign bus.HWDATA = hwdata_q;
    assign bus.busy   = state_q != IDLE;
    assign bus.step   = step_q;
    assign bus.wrap   = wrap_q;
endmodule

// File: tb/tb_ahb_led_sequencer.sv
// tb_ahb_led_sequencer: scoreboard bench; a bus monitor records accepted writes, each test compares them to expectations.
module tb_ahb_led_sequencer;
    localparam logic [31:0] BASE = 32'h5000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0, errors = 0, cyc = 0, wraps = 0;
    bit          pend = 0, last_ns = 0, b2b = 0;
    logic [31:0] paddr;
    logic [63:0] exp_q[$], obs_q[$];
    logic [63:0] e, o;
    int          acyc[$];

    ahb_led_sequencer_if #(.DIV_WIDTH(24)) bus();
    ahb_led_sequencer #(.BASE_ADDR(BASE), .DIV_WIDTH(24)) dut (.HCLK(clk), .HRESET(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Records every accepted write as {address, data}, plus the cycle of each accepted data-register address phase.
    always @(negedge clk) begin
        if (rst) begin
            pend = 0;
            last_ns = 0;
        end else if (bus.HREADY) begin
            if (pend) begin
                obs_q.push_back({paddr, bus.HWDATA});
                pend = 0;
            end
            if (bus.HTRANS == 2'b10) begin
                if (last_ns) b2b = 1;
                pend = 1;
                paddr = bus.HADDR;
                if (bus.HADDR == BASE) acyc.push_back(cyc);
            end
            last_ns = bus.HTRANS == 2'b10;
        end
        if (!rst && bus.wrap) wraps++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
        bus.cfg_we = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_wdata = d;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic setup(input logic [2:0] len, input logic [7:0] mask, input logic [23:0] per, input logic os);
        bus.cfg_len = len;
        bus.cfg_mask = mask;
        bus.cfg_period = per;
        bus.one_shot = os;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        acyc.delete();
        wraps = 0;
        b2b = 0;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [7:0] d);
        exp_q.push_back({a, 24'h0, d});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && bus.busy; i++) tick();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        clear_sb();
        cfg_write(3'd0, 8'h11);
        cfg_write(3'd1, 8'h22);
        cfg_write(3'd2, 8'h33);
        cfg_write(3'd3, 8'h44);
        setup(3'd3, 8'h00, 24'd0, 1'b0);
        pulse_start();
        for (int i = 0; i < 100 && acyc.size() < 3; i++) tick();
        checks++;
        if (acyc.size() < 3 || bus.step !== 3'd1) begin
            errors++;
            $display("FAIL reset_pre step got %0d want 1 (data phases %0d)", bus.step, acyc.size());
        end
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (bus.HTRANS !== 2'b00 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus htrans %b busy %b want 00 0", bus.HTRANS, bus.busy);
        end
        checks++;
        if (bus.HWDATA !== 32'h0 || bus.HADDR !== 32'h0) begin
            errors++;
            $display("FAIL reset_data hwdata %h haddr %h want 0 0", bus.HWDATA, bus.HADDR);
        end
        checks++;
        if (bus.step !== 3'd0 || bus.wrap !== 1'b0 || bus.HWRITE !== 1'b0) begin
            errors++;
            $display("FAIL reset_status step %0d wrap %b hwrite %b want 0 0 0", bus.step, bus.wrap, bus.HWRITE);
        end
        tick();
        rst = 1'b0;
        tick();
        clear_sb();
        // Table was cleared by reset: a one-entry one-shot plays a zero.
        setup(3'd0, 8'h3C, 24'd1, 1'b1);
        push_exp(BASE + 32'd1, 8'h3C);
        push_exp(BASE, 8'h00);
        pulse_start();
        wait_idle();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL reset_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_xfer got %h want %h", o, e);
            end
        end
        checks++;
        if (wraps != 1) begin
            errors++;
            $display("FAIL reset_len0_wrap got %0d want 1", wraps);
        end
    endtask

    task automatic test_loop();
        logic [7:0] led [4];
        led = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
        clear_sb();
        cfg_write(3'd0, 8'h01);
        cfg_write(3'd1, 8'h02);
        cfg_write(3'd2, 8'h04);
        cfg_write(3'd3, 8'h08);
        setup(3'd3, 8'hFF, 24'd3, 1'b0);
        push_exp(BASE + 32'd1, 8'hFF);
        push_exp(BASE, 8'h01);
        push_exp(BASE, 8'h02);
        push_exp(BASE, 8'h04);
        push_exp(BASE, 8'h08);
        push_exp(BASE, 8'h01);
        pulse_start();
        @(negedge clk);
        checks++;
        if (bus.HTRANS !== 2'b10 || bus.HADDR !== BASE + 32'd1 || bus.HWRITE !== 1'b1 || bus.HSIZE !== 3'b000) begin
            errors++;
            $display("FAIL loop_latency htrans %b haddr %h hwrite %b hsize %b", bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE);
        end
        for (int i = 0; i < 200 && obs_q.size() < 6; i++) tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        repeat (10) tick();
        checks++;
        if (wraps != 1 || b2b) begin
            errors++;
            $display("FAIL loop_wrap wraps %0d b2b %0d want 1 0", wraps, b2b);
        end
        checks++;
        if (acyc.size() != 5) begin
            errors++;
            $display("FAIL loop_phases got %0d want 5", acyc.size());
        end
        for (int k = 1; k < acyc.size(); k++) begin
            checks++;
            if (acyc[k] - acyc[k-1] != 5) begin
                errors++;
                $display("FAIL loop_spacing got %0d want 5", acyc[k] - acyc[k-1]);
            end
        end
        for (int k = 1; k < 5 && k < obs_q.size(); k++) begin
            checks++;
            if ((obs_q[k][7:0] ^ obs_q[0][7:0]) !== led[k-1]) begin
                errors++;
                $display("FAIL loop_led got %h want %h", obs_q[k][7:0] ^ obs_q[0][7:0], led[k-1]);
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL loop_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL loop_xfer got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_one_shot();
        clear_sb();
        cfg_write(3'd0, 8'hAA);
        cfg_write(3'd1, 8'h55);
        setup(3'd1, 8'h0F, 24'd2, 1'b1);
        push_exp(BASE + 32'd1, 8'h0F);
        push_exp(BASE, 8'hAA);
        push_exp(BASE, 8'h55);
        pulse_start();
        wait_idle();
        checks++;
        if (bus.busy !== 1'b0 || wraps != 1 || bus.step !== 3'd1) begin
            errors++;
            $display("FAIL oneshot_end busy %b wraps %0d step %0d want 0 1 1", bus.busy, wraps, bus.step);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL oneshot_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL oneshot_xfer got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_wait_states();
        clear_sb();
        cfg_write(3'd0, 8'h9A);
        cfg_write(3'd1, 8'hB7);
        setup(3'd1, 8'h80, 24'd1, 1'b1);
        push_exp(BASE + 32'd1, 8'h80);
        push_exp(BASE, 8'h9A);
        push_exp(BASE, 8'hB7);
        pulse_start();
        bus.HREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.HTRANS !== 2'b10 || bus.HADDR !== BASE + 32'd1) begin
                errors++;
                $display("FAIL ws_addr_hold htrans %b haddr %h want 10 %h", bus.HTRANS, bus.HADDR, BASE + 32'd1);
            end
            tick();
        end
        bus.HREADY = 1'b1;
        for (int i = 0; i < 50 && !(bus.HTRANS == 2'b10 && bus.HADDR == BASE); i++) tick();
        tick();
        bus.HREADY = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (bus.HWDATA !== 32'h0000_009A) begin
                errors++;
                $display("FAIL ws_data_hold got %h want 0000009a", bus.HWDATA);
            end
            tick();
        end
        bus.HREADY = 1'b1;
        wait_idle();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL ws_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL ws_xfer got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_stop();
        cfg_write(3'd0, 8'hC1);
        cfg_write(3'd1, 8'hC2);
        cfg_write(3'd2, 8'hC3);
        cfg_write(3'd3, 8'hC4);
        setup(3'd3, 8'h5A, 24'd3, 1'b0);
        for (int s = 0; s < 2; s++) begin
            clear_sb();
            push_exp(BASE + 32'd1, 8'h5A);
            push_exp(BASE, 8'hC1);
            pulse_start();
            for (int i = 0; i < 50 && !(bus.HTRANS == 2'b10 && bus.HADDR == BASE); i++) tick();
            tick();
            if (s == 1) tick();
            bus.stop = 1'b1;
            tick();
            bus.stop = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0 || bus.HTRANS !== 2'b00) begin
                errors++;
                $display("FAIL stop_idle case %0d busy %b htrans %b want 0 00", s, bus.busy, bus.HTRANS);
            end
            repeat (12) tick();
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL stop_count case %0d got %0d want %0d", s, obs_q.size(), exp_q.size());
            end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL stop_xfer case %0d got %h want %h", s, o, e);
                end
            end
        end
        clear_sb();
        bus.start = 1'b1;
        bus.stop = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop = 1'b0;
        repeat (8) tick();
        checks++;
        if (bus.busy !== 1'b0 || obs_q.size() != 0 || bus.HTRANS !== 2'b00) begin
            errors++;
            $display("FAIL stop_with_start busy %b writes %0d htrans %b want 0 0 00", bus.busy, obs_q.size(), bus.HTRANS);
        end
    endtask

    task automatic test_live_update();
        int gap [3];
        gap = '{4, 4, 2};
        clear_sb();
        cfg_write(3'd0, 8'h10);
        cfg_write(3'd1, 8'h20);
        cfg_write(3'd2, 8'h30);
        cfg_write(3'd3, 8'h40);
        setup(3'd3, 8'h00, 24'd2, 1'b1);
        push_exp(BASE + 32'd1, 8'h00);
        push_exp(BASE, 8'h10);
        push_exp(BASE, 8'h20);
        push_exp(BASE, 8'h3C);
        push_exp(BASE, 8'h40);
        pulse_start();
        for (int i = 0; i < 100 && obs_q.size() < 3; i++) tick();
        bus.cfg_period = 24'd0;
        cfg_write(3'd2, 8'h3C);
        wait_idle();
        checks++;
        if (acyc.size() != 4 || wraps != 1 || bus.step !== 3'd3) begin
            errors++;
            $display("FAIL live_end phases %0d wraps %0d step %0d want 4 1 3", acyc.size(), wraps, bus.step);
        end
        for (int k = 1; k < acyc.size() && k < 4; k++) begin
            checks++;
            if (acyc[k] - acyc[k-1] != gap[k-1]) begin
                errors++;
                $display("FAIL live_spacing got %0d want %0d", acyc[k] - acyc[k-1], gap[k-1]);
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL live_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL live_xfer got %h want %h", o, e);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.one_shot = 1'b0;
        bus.cfg_we = 1'b0;
        bus.cfg_addr = 3'd0;
        bus.cfg_wdata = 8'h00;
        bus.cfg_len = 3'd0;
        bus.cfg_period = 24'd0;
        bus.cfg_mask = 8'h00;
        bus.HREADY = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_loop();
        test_one_shot();
        test_wait_states();
        test_stop();
        test_live_update();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
